// File: rtl/program_loader.sv
// program_loader: receives a framed byte stream (LEN, LEN instruction bytes,
// CSUM) over valid/ready, writes it into instruction memory, verifies the XOR
// checksum, zero-fills unused slots and then releases the CPU from reset.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous active-high reset (control state only)
//   in_data       stream byte
//   in_valid      in_data valid
//   in_ready      loader accepts a byte (registered, decoded from state)
//   reload        single-cycle request to go from RUN back to loading
//   imem_rd_addr  instruction fetch address (CPU pc)
//   imem_rd_data  mem[imem_rd_addr], asynchronous read
//   cpu_reset     CPU reset, low only while running (registered)
//   loaded        high while running (registered)
//   err           sticky error flag
module program_loader #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned INSTR_W = 8,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               reload,
    input  logic [AW-1:0]      imem_rd_addr,
    output logic [INSTR_W-1:0] imem_rd_data,
    output logic               cpu_reset,
    output logic               loaded,
    output logic               err
);

    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_FILL = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [CW-1:0]      len, len_nxt;
    logic [INSTR_W-1:0] acc, acc_nxt;
    logic               err_nxt;
    logic               in_ready_nxt, cpu_reset_nxt, loaded_nxt;

    logic               mem_we;
    logic [AW-1:0]      mem_wa;
    logic [INSTR_W-1:0] mem_wd;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               accept;

    // in_ready is already a pure function of the registered state
    assign accept = in_valid && in_ready;

    // Next-state, datapath updates and memory write request
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        len_nxt   = len;
        acc_nxt   = acc;
        err_nxt   = err;
        mem_we    = 1'b0;
        mem_wa    = cnt[AW-1:0];
        mem_wd    = '0;

        case (state)
            ST_HDR: begin
                if (accept) begin
                    if ((in_data == '0) || (in_data > INSTR_W'(DEPTH))) begin
                        err_nxt = 1'b1;
                    end else begin
                        len_nxt   = CW'(in_data);
                        acc_nxt   = in_data;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        state_nxt = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    mem_we  = 1'b1;
                    mem_wd  = in_data;
                    acc_nxt = acc ^ in_data;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt_nxt == len) begin
                        state_nxt = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (in_data == acc) begin
                        state_nxt = (len == CW'(DEPTH)) ? ST_RUN : ST_FILL;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = ST_HDR;
                    end
                end
            end
            ST_FILL: begin
                // cnt starts at len and walks to the last slot writing NOPs
                mem_we  = 1'b1;
                mem_wd  = '0;
                cnt_nxt = cnt + CW'(1);
                if (cnt == CW'(DEPTH - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_nxt = ST_HDR;
                end
            end
            default: begin
                state_nxt = ST_HDR;
            end
        endcase
    end

    // Output decode from the next state so the flops track the state register
    always_comb begin
        in_ready_nxt  = 1'b0;
        cpu_reset_nxt = 1'b1;
        loaded_nxt    = 1'b0;
        case (state_nxt)
            ST_HDR, ST_DATA, ST_CSUM: in_ready_nxt = 1'b1;
            ST_RUN: begin
                cpu_reset_nxt = 1'b0;
                loaded_nxt    = 1'b1;
            end
            default: ;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_HDR;
            cnt       <= '0;
            len       <= '0;
            acc       <= '0;
            err       <= 1'b0;
            in_ready  <= 1'b1;
            cpu_reset <= 1'b1;
            loaded    <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            len       <= len_nxt;
            acc       <= acc_nxt;
            err       <= err_nxt;
            in_ready  <= in_ready_nxt;
            cpu_reset <= cpu_reset_nxt;
            loaded    <= loaded_nxt;
        end
    end

    // Instruction memory: one write port, untouched by reset
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    assign imem_rd_data = mem[imem_rd_addr];

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader with a frame-level model.
module tb_program_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       reload;
    logic [3:0] imem_rd_addr;
    logic [7:0] imem_rd_data;
    logic       cpu_reset;
    logic       loaded;
    logic       err;

    int total = 0;
    int bad   = 0;

    // Reference memory image and which slots have a defined value
    logic [7:0] mdl [16];
    bit         known [16];

    program_loader dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .reload       (reload),
        .imem_rd_addr (imem_rd_addr),
        .imem_rd_data (imem_rd_data),
        .cpu_reset    (cpu_reset),
        .loaded       (loaded),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // gap_mode: 0 none, 1 random idle cycles, 2 idle cycle before every byte
    task automatic send_byte(input logic [7:0] b, input int gap_mode);
        int n;
        if (gap_mode == 2 || (gap_mode == 1 && $urandom_range(1) == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            cyc();
        end
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 4) begin
            cyc();
            n++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 16; i++) begin
            if (known[i]) begin
                imem_rd_addr = 4'(i);
                #1;
                chk($sformatf("%s_mem%0d", tag, i), 32'(imem_rd_data), 32'(mdl[i]));
            end
        end
        cyc();
    endtask

    // Sends LEN, payload, CSUM and checks the outcome against the frame rules
    task automatic run_frame(input string tag, input logic [7:0] d[$],
                             input logic [7:0] csum, input int gap_mode);
        logic [7:0] x;
        int         len;
        int         k;
        bit         good;
        len = d.size();
        x   = 8'(len);
        send_byte(8'(len), gap_mode);
        chk({tag, "_err_clr"}, 32'(err), 32'd0);
        for (int i = 0; i < len; i++) begin
            send_byte(d[i], gap_mode);
            x ^= d[i];
            mdl[i]   = d[i];
            known[i] = 1'b1;
        end
        good = (csum == x);
        send_byte(csum, gap_mode);
        if (good) begin
            // keep in_valid high with junk during fill: must be ignored
            k = 1;
            while (cpu_reset && k < 40) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                cyc();
                k++;
            end
            in_valid = 1'b0;
            chk({tag, "_latency"}, 32'(k), 32'(1 + 16 - len));
            for (int i = len; i < 16; i++) begin
                mdl[i]   = 8'h00;
                known[i] = 1'b1;
            end
            cyc();
            chk({tag, "_loaded"}, 32'(loaded), 32'd1);
            chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd0);
            chk({tag, "_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'd0);
        end else begin
            chk({tag, "_err"}, 32'(err), 32'd1);
            chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
            chk({tag, "_ready"}, 32'(in_ready), 32'd1);
            chk({tag, "_loaded"}, 32'(loaded), 32'd0);
        end
        check_mem(tag);
    endtask

    task automatic do_reload(input string tag);
        reload = 1'b1;
        cyc();
        reload = 1'b0;
        chk({tag, "_cpurst"}, 32'(cpu_reset), 32'd1);
        chk({tag, "_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_loaded"}, 32'(loaded), 32'd0);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] cs;
        int         len;

        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        reload       = 1'b0;
        imem_rd_addr = 4'h0;
        for (int i = 0; i < 16; i++) known[i] = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_cpurst", 32'(cpu_reset), 32'd1);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Short frame with fill
        q = {8'h11, 8'h22, 8'h33};
        run_frame("short", q, 8'h03, 0);
        do_reload("reload1");

        // Same frame with an idle cycle before every byte
        run_frame("gaps", q, 8'h03, 2);
        do_reload("reload2");

        // Full frame, no fill
        q = {};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        run_frame("full", q, 8'h10, 0);
        imem_rd_addr = 4'd7;
        #1;
        chk("full_addr7", 32'(imem_rd_data), 32'h07);
        do_reload("reload3");

        // Bad checksum, then recovery
        q = {8'hAA, 8'h55};
        run_frame("badcs", q, 8'h00, 0);
        q = {8'h44};
        run_frame("recover", q, 8'h45, 0);
        do_reload("reload4");

        // Illegal LEN bytes
        send_byte(8'h00, 0);
        chk("len0_err", 32'(err), 32'd1);
        chk("len0_ready", 32'(in_ready), 32'd1);
        send_byte(8'h11, 0);
        chk("len17_err", 32'(err), 32'd1);
        chk("len17_ready", 32'(in_ready), 32'd1);
        q = {8'h7E};
        run_frame("len1", q, 8'h7F, 0);
        do_reload("reload5");

        // Randomized frames, a quarter with a corrupted checksum
        for (int f = 0; f < 10; f++) begin
            len = int'($urandom_range(16, 1));
            q   = {};
            cs  = 8'(len);
            for (int i = 0; i < len; i++) begin
                q.push_back(8'($urandom));
                cs ^= q[i];
            end
            if ($urandom_range(3) == 0) cs ^= 8'($urandom_range(255, 1));
            run_frame($sformatf("rnd%0d", f), q, cs, 1);
            if (loaded) do_reload($sformatf("rnd%0d_rl", f));
        end

        // Reset in the middle of DATA
        send_byte(8'h04, 0);
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        mdl[0] = 8'hA1; known[0] = 1'b1;
        mdl[1] = 8'hB2; known[1] = 1'b1;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("midrst_ready", 32'(in_ready), 32'd1);
        chk("midrst_cpurst", 32'(cpu_reset), 32'd1);
        chk("midrst_err", 32'(err), 32'd0);
        check_mem("midrst");
        // cnt must restart at 0: the next byte lands in slot 0
        q = {8'hC3};
        run_frame("afterrst", q, 8'hC2, 0);

        // reset and reload together while running
        reset  = 1'b1;
        reload = 1'b1;
        cyc();
        reset  = 1'b0;
        reload = 1'b0;
        chk("rstrl_cpurst", 32'(cpu_reset), 32'd1);
        chk("rstrl_ready", 32'(in_ready), 32'd1);
        chk("rstrl_loaded", 32'(loaded), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
